// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle RV32I core
// Ports: clk/reset_n; imem_req_o/imem_valid_i/insn_i fetch handshake;
// insn_o/opcode_o latched instruction; br_taken_i branch result (EXEC);
// alu_src_a_o/alu_src_b_o operand selects; dmem_req_o/dmem_we_o/dmem_valid_i
// data handshake; rf_we_o/wb_sel_o writeback; pc_we_o/pc_sel_o PC update;
// retire_o/retire_cnt_o retirement; trap_o/trap_cause_o sticky trap.
module multicycle_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_o,
  input  logic              imem_valid_i,
  input  logic [DWIDTH-1:0] insn_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  input  logic              br_taken_i,
  output logic              alu_src_a_o,
  output logic              alu_src_b_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  input  logic              dmem_valid_i,
  output logic              rf_we_o,
  output logic [1:0]        wb_sel_o,
  output logic              pc_we_o,
  output logic              pc_sel_o,
  output logic              retire_o,
  output logic [31:0]       retire_cnt_o,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam bit          TO_EN     = TIMEOUT != 0;
  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);
  logic [2:0]  state, state_nx;
  logic [1:0]  cause_nx;
  logic [31:0] wait_cnt;
  logic        is_br, is_ld, is_st, is_jump, legal, timed_out;
  logic        in_exec, in_mem, in_wb, br_done, st_done;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  assign opcode_o = insn_o[6:0];
  assign funct3   = insn_o[14:12];
  assign funct7   = insn_o[31:25];
  assign is_br    = opcode_o == OP_BR;
  assign is_ld    = opcode_o == OP_LOAD;
  assign is_st    = opcode_o == OP_STORE;
  assign is_jump  = opcode_o == OP_JAL || opcode_o == OP_JALR;
  // Shift-immediate forms carry funct7 in the immediate field and must be checked.
  assign legal = opcode_o == OP_IMM ? !(funct3 == 3'd1 && funct7 != 7'h00) &&
                                      !(funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20)
               : opcode_o inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
                                  OP_LOAD, OP_STORE, OP_REG};
  // The current wait cycle is the TIMEOUT-th one; a valid in this cycle still wins.
  assign timed_out = TO_EN && wait_cnt == WAIT_LAST;
  always_comb begin
    state_nx = state;
    cause_nx = trap_cause_o;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  begin
        state_nx = imem_valid_i ? S_DECODE : timed_out ? S_TRAP : S_FETCH;
        cause_nx = !imem_valid_i && timed_out ? 2'd2 : trap_cause_o;
      end
      S_DECODE: begin
        state_nx = legal ? S_EXEC : S_TRAP;
        cause_nx = legal ? trap_cause_o : 2'd1;
      end
      S_EXEC:   state_nx = is_br ? S_FETCH : (is_ld || is_st) ? S_MEM : S_WB;
      S_MEM:    begin
        state_nx = dmem_valid_i ? (is_st ? S_FETCH : S_WB) : timed_out ? S_TRAP : S_MEM;
        cause_nx = !dmem_valid_i && timed_out ? 2'd3 : trap_cause_o;
      end
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      insn_o       <= DWIDTH'(32'h0000_0013);
      retire_cnt_o <= '0;
      trap_cause_o <= '0;
      wait_cnt     <= '0;
    end else begin
      state        <= state_nx;
      trap_cause_o <= cause_nx;
      if (state == S_FETCH && imem_valid_i) insn_o <= insn_i;
      if (retire_o) retire_cnt_o <= retire_cnt_o + 32'd1;
      // Cleared whenever a wait ends, so every FETCH/MEM entry starts from zero.
      wait_cnt <= ((state == S_FETCH && !imem_valid_i) || (in_mem && !dmem_valid_i))
                  ? wait_cnt + 32'd1 : '0;
    end
  end
  assign in_exec     = state == S_EXEC;
  assign in_mem      = state == S_MEM;
  assign in_wb       = state == S_WB;
  assign br_done     = in_exec && is_br;
  assign st_done     = in_mem && is_st && dmem_valid_i;
  assign imem_req_o  = state == S_FETCH;
  assign dmem_req_o  = in_mem;
  assign dmem_we_o   = in_mem && is_st;
  assign alu_src_a_o = in_exec && (opcode_o == OP_AUIPC || opcode_o == OP_JAL || is_br);
  assign alu_src_b_o = in_exec && opcode_o != OP_REG;
  assign rf_we_o     = in_wb && insn_o[11:7] != 5'd0;
  assign wb_sel_o    = !in_wb ? 2'b00 : is_ld ? 2'b01 : is_jump ? 2'b10 : 2'b00;
  assign pc_we_o     = br_done || st_done || in_wb;
  assign pc_sel_o    = br_done ? br_taken_i : in_wb && is_jump;
  assign retire_o    = pc_we_o;
  assign trap_o      = state == S_TRAP;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vector bench for multicycle_ctrl
module tb_multicycle_ctrl;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        imem_req_o, imem_valid_i = 0;
  logic [31:0] insn_i = 0, insn_o;
  logic [6:0]  opcode_o;
  logic        br_taken_i = 0, alu_src_a_o, alu_src_b_o;
  logic        dmem_req_o, dmem_we_o, dmem_valid_i = 0;
  logic        rf_we_o, pc_we_o, pc_sel_o, retire_o, trap_o;
  logic [1:0]  wb_sel_o, trap_cause_o;
  logic [31:0] retire_cnt_o;
  int          total = 0, passed = 0, exp_cnt = 0;
  multicycle_ctrl #(.DWIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_o(imem_req_o), .imem_valid_i(imem_valid_i), .insn_i(insn_i),
    .insn_o(insn_o), .opcode_o(opcode_o), .br_taken_i(br_taken_i),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_valid_i(dmem_valid_i),
    .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
    .retire_o(retire_o), .retire_cnt_o(retire_cnt_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] insn;
    bit          br;
    int          idly, ddly, cyc;
    bit          rf_we;
    logic [1:0]  wb_sel;
    bit          pc_sel, a, b;
    int          dreq;
    bit          dwe;
  } vec_t;
  vec_t vt[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [31:0] strobes();
    return 32'({imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, retire_o,
                alu_src_a_o, alu_src_b_o, wb_sel_o, pc_sel_o});
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    imem_valid_i = 0;
    dmem_valid_i = 0;
    br_taken_i = 0;
    #1;
    chk("reset insn", insn_o, 32'h13);
    chk("reset cnt", retire_cnt_o, 0);
    chk("reset trap", 32'({trap_o, trap_cause_o}), 0);
    chk("reset strobes", strobes(), 0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    #1 chk("idle no fetch", 32'(imem_req_o), 0);
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, ic = 0, dc = 0;
    bit done = 0, dwe = 0;
    logic a = 0, b = 0, rf = 0, pcw = 0, pcs = 0;
    logic [1:0] wb = 0;
    logic [31:0] ins = 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      imem_valid_i = imem_req_o && ic == v.idly;
      if (imem_req_o) ic++;
      dmem_valid_i = dmem_req_o && dc == v.ddly;
      if (dmem_req_o) dc++;
      insn_i = v.insn;
      br_taken_i = v.br;
      #1;
      dwe |= dmem_we_o;
      if (cyc == v.idly + 3) begin
        a = alu_src_a_o;
        b = alu_src_b_o;
      end
      if (retire_o) begin
        done = 1;
        rf = rf_we_o;
        wb = wb_sel_o;
        pcw = pc_we_o;
        pcs = pc_sel_o;
        ins = insn_o;
      end
    end
    if (done) exp_cnt++;
    chk($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.cyc));
    chk($sformatf("v%0d insn", idx), ins, v.insn);
    chk($sformatf("v%0d rf_we", idx), 32'(rf), 32'(v.rf_we));
    chk($sformatf("v%0d wb_sel", idx), 32'(wb), 32'(v.wb_sel));
    chk($sformatf("v%0d pc_we", idx), 32'(pcw), 1);
    chk($sformatf("v%0d pc_sel", idx), 32'(pcs), 32'(v.pc_sel));
    chk($sformatf("v%0d alu_a", idx), 32'(a), 32'(v.a));
    chk($sformatf("v%0d alu_b", idx), 32'(b), 32'(v.b));
    chk($sformatf("v%0d dmem cycles", idx), 32'(dc), 32'(v.dreq));
    chk($sformatf("v%0d dmem_we", idx), 32'(dwe), 32'(v.dwe));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d retire_cnt", idx), retire_cnt_o, 32'(exp_cnt));
    chk($sformatf("v%0d no trap", idx), 32'(trap_o), 0);
  endtask
  task automatic run_trap(input string name, input logic [31:0] insn, input bit ihang,
                          input bit dhang, input int exp_cyc, input logic [1:0] cause,
                          input logic [31:0] exp_insn);
    int cyc = 0, tcyc = 0;
    bit ret = 0;
    while (tcyc == 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      imem_valid_i = imem_req_o && !ihang;
      dmem_valid_i = dmem_req_o && !dhang;
      insn_i = insn;
      br_taken_i = 0;
      #1;
      ret |= retire_o;
      if (!trap_o) chk({name, " trap low before"}, 32'(trap_cause_o), 0);
      else tcyc = cyc;
    end
    chk({name, " trap cycle"}, 32'(tcyc), 32'(exp_cyc));
    chk({name, " cause"}, 32'(trap_cause_o), 32'(cause));
    chk({name, " no retire"}, 32'(ret), 0);
    chk({name, " strobes"}, strobes(), 0);
    repeat (3) begin
      @(negedge clk);
      imem_valid_i = 1;
      dmem_valid_i = 1;
      br_taken_i = 1;
      insn_i = 32'h00500093;
    end
    #1;
    chk({name, " trap sticky"}, 32'({trap_o, trap_cause_o}), 32'({1'b1, cause}));
    chk({name, " strobes held 0"}, strobes(), 0);
    chk({name, " insn held"}, insn_o, exp_insn);
    chk({name, " cnt held"}, retire_cnt_o, 32'(exp_cnt));
  endtask
  initial begin
    int n;
    vt[0]  = '{32'h00500093, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0, 0};
    vt[1]  = '{32'h0000A103, 0, 0, 3, 8, 1, 2'd1, 0, 0, 1, 4, 0};
    vt[2]  = '{32'h00208463, 1, 0, 0, 3, 0, 2'd0, 1, 1, 1, 0, 0};
    vt[3]  = '{32'h00208463, 0, 0, 0, 3, 0, 2'd0, 0, 1, 1, 0, 0};
    vt[4]  = '{32'h0020A223, 0, 0, 0, 4, 0, 2'd0, 0, 0, 1, 1, 1};
    vt[5]  = '{32'h002081B3, 0, 0, 0, 4, 1, 2'd0, 0, 0, 0, 0, 0};
    vt[6]  = '{32'h123452B7, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0, 0};
    vt[7]  = '{32'h00001317, 0, 0, 0, 4, 1, 2'd0, 0, 1, 1, 0, 0};
    vt[8]  = '{32'h0100006F, 0, 0, 0, 4, 0, 2'd2, 1, 1, 1, 0, 0};
    vt[9]  = '{32'h010000EF, 0, 0, 0, 4, 1, 2'd2, 1, 1, 1, 0, 0};
    vt[10] = '{32'h000100E7, 0, 0, 0, 4, 1, 2'd2, 1, 0, 1, 0, 0};
    vt[11] = '{32'h4030D213, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0, 0};
    vt[12] = '{32'h00500093, 0, 2, 0, 6, 1, 2'd0, 0, 0, 1, 0, 0};
    vt[13] = '{32'h00500093, 0, 15, 0, 19, 1, 2'd0, 0, 0, 1, 0, 0};
    vt[14] = '{32'h0020A223, 0, 0, 15, 19, 0, 2'd0, 0, 0, 1, 16, 1};
    vt[15] = '{32'h0000A003, 0, 0, 0, 5, 0, 2'd1, 0, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 16; i++) run_vec(vt[i], i);
    run_trap("illegal", 32'h40101093, 0, 0, 3, 2'd1, 32'h40101093);
    do_reset();
    run_trap("imem timeout", 32'h00500093, 1, 0, 17, 2'd2, 32'h13);
    do_reset();
    run_trap("dmem timeout", 32'h0000A103, 0, 1, 20, 2'd3, 32'h0000A103);
    do_reset();
    run_vec(vt[0], 100);
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      imem_valid_i = imem_req_o;
      dmem_valid_i = 0;
      insn_i = 32'h0000A103;
      #1;
      if (dmem_req_o) n++;
    end
    chk("mid mem reached", 32'(n), 3);
    reset_n = 0;
    #1;
    chk("mid reset dmem_req", 32'(dmem_req_o), 0);
    chk("mid reset insn", insn_o, 32'h13);
    chk("mid reset cnt", retire_cnt_o, 0);
    chk("mid reset strobes", strobes(), 0);
    do_reset();
    run_vec(vt[0], 101);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
